// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the multiply/divide unit: operation
//               encodings, FSM state type, iteration count and data width.
//               Build option: MDU_FAST_MULT_EN (consumed by mul_div_unit).
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int XLEN       = 32;
    localparam int ITER_COUNT = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Signed variants treat both operands as two's complement.
    function automatic logic op_is_signed(input logic [2:0] code);
        return (code == OP_MULT) || (code == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_divider.sv
`default_nettype none
// ============================================================================
// Module      : mdu_divider
// Description : Unsigned 32/32 restoring divider core, one quotient bit per
//               step. The next-step quotient/remainder are exported
//               combinationally so the caller can capture the final result on
//               the same edge as the last step.
// Ports       : clk, rst (async, active-low), load (capture operands),
//               step (advance one iteration), dividend, divisor,
//               quo_next / rem_next (result of the current step)
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_divider
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_next,
    output logic [XLEN-1:0] rem_next
);

    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_fits;

    // Shift the next dividend bit into the partial remainder and trial-
    // subtract. The partial remainder stays below the divisor, so the shifted
    // value fits 33 bits and bit 32 of the difference is a clean borrow flag.
    // A zero divisor always "fits": quotient all ones, remainder = dividend.
    always_comb begin
        w_shift  = {r_rem, r_quo[XLEN-1]};
        w_diff   = w_shift - {1'b0, r_dvs};
        w_fits   = ~w_diff[XLEN];
        rem_next = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
        quo_next = {r_quo[XLEN-2:0], w_fits};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (load) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_dvs <= divisor;
        end else if (step) begin
            r_rem <= rem_next;
            r_quo <= quo_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : HI/LO multiply/divide unit. 32-iteration shift-add multiply
//               and restoring divide on operand magnitudes, sign fix-up at
//               write-back, MTHI/MTLO single-cycle moves.
//               Build option MDU_FAST_MULT_EN: MULT/MULTU complete on the
//               accept edge without entering RUN.
// Ports       : clk, rst (async, active-low), opA/opB (operands), start,
//               op (operation code), busy, done (1-cycle completion pulse),
//               hi, lo (result registers)
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        start,
    input  logic [2:0]  op,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t          r_state;
    state_t          w_state_next;
    logic [4:0]      r_count;
    logic            r_done;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;

    logic            r_is_div;
    logic            r_neg_p;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_div0;
    logic [XLEN-1:0] r_opa;
    logic [63:0]     r_prod;
    logic [XLEN-1:0] r_mcand;

    logic            w_accept;
    logic            w_is_long;
    logic            w_last;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN:0]   w_msum;
    logic [63:0]     w_prod_next;
    logic [63:0]     w_prod_fin;
    logic [XLEN-1:0] w_div_q;
    logic [XLEN-1:0] w_div_r;
    logic [XLEN-1:0] w_quo_fin;
    logic [XLEN-1:0] w_rem_fin;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        busy         = 1'b0;
`ifdef MDU_FAST_MULT_EN
        w_is_long    = (op == OP_DIV) || (op == OP_DIVU);
`else
        w_is_long    = (op == OP_MULT) || (op == OP_MULTU) ||
                       (op == OP_DIV)  || (op == OP_DIVU);
`endif
        case (r_state)
            IDLE: begin
                w_accept = start;
                if (start && w_is_long) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                w_last = (r_count == 5'(ITER_COUNT - 1));
                if (w_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------ operand prep
    always_comb begin
        w_a_neg = op_is_signed(op) & opA[31];
        w_b_neg = op_is_signed(op) & opB[31];
        w_a_mag = w_a_neg ? (32'd0 - opA) : opA;
        w_b_mag = w_b_neg ? (32'd0 - opB) : opB;
    end

    // --------------------------------------------------- multiply step
    // r_prod holds {partial product, remaining multiplier bits}; each step
    // conditionally adds the multiplicand to the upper half and shifts right.
    always_comb begin
        w_msum      = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_mcand} : 33'd0);
        w_prod_next = {w_msum, r_prod[31:1]};
        w_prod_fin  = r_neg_p ? (64'd0 - w_prod_next) : w_prod_next;
    end

    // ----------------------------------------------------- divide core
    mdu_divider u_divider (
        .clk      (clk),
        .rst      (rst),
        .load     (w_accept && ((op == OP_DIV) || (op == OP_DIVU))),
        .step     (busy && r_is_div),
        .dividend (w_a_mag),
        .divisor  (w_b_mag),
        .quo_next (w_div_q),
        .rem_next (w_div_r)
    );

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    always_comb begin
        w_quo_fin = r_neg_q ? (32'd0 - w_div_q) : w_div_q;
        w_rem_fin = r_neg_r ? (32'd0 - w_div_r) : w_div_r;
    end

`ifdef MDU_FAST_MULT_EN
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_fast_prod;

    // Truncating a 64x64 product of properly extended operands yields the
    // correct signed or unsigned 64-bit result.
    always_comb begin
        w_ext_a     = op_is_signed(op) ? {{32{opA[31]}}, opA} : {32'd0, opA};
        w_ext_b     = op_is_signed(op) ? {{32{opB[31]}}, opB} : {32'd0, opB};
        w_fast_prod = w_ext_a * w_ext_b;
    end
`endif

    // ------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= '0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_p  <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_opa    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                case (op)
                    OP_MTHI: begin
                        r_hi   <= opA;
                        r_done <= 1'b1;
                    end
                    OP_MTLO: begin
                        r_lo   <= opA;
                        r_done <= 1'b1;
                    end
                    OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MULT_EN
                        r_hi   <= w_fast_prod[63:32];
                        r_lo   <= w_fast_prod[31:0];
                        r_done <= 1'b1;
`else
                        r_is_div <= 1'b0;
                        r_count  <= '0;
                        r_prod   <= {32'd0, w_b_mag};
                        r_mcand  <= w_a_mag;
                        r_neg_p  <= w_a_neg ^ w_b_neg;
`endif
                    end
                    OP_DIV, OP_DIVU: begin
                        r_is_div <= 1'b1;
                        r_count  <= '0;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_div0   <= (opB == 32'd0);
                        r_opa    <= opA;
                    end
                    default: ;
                endcase
            end
            if (busy) begin
                r_count <= r_count + 5'd1;
                r_prod  <= w_prod_next;
                if (w_last) begin
                    r_done <= 1'b1;
                    if (!r_is_div) begin
                        r_hi <= w_prod_fin[63:32];
                        r_lo <= w_prod_fin[31:0];
                    end else if (r_div0) begin
                        // Divide by zero bypasses sign fix-up entirely.
                        r_hi <= r_opa;
                        r_lo <= 32'hFFFF_FFFF;
                    end else begin
                        r_hi <= w_rem_fin;
                        r_lo <= w_quo_fin;
                    end
                end
            end
        end
    end

    always_comb begin
        done = r_done;
        hi   = r_hi;
        lo   = r_lo;
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed self-checking bench for mul_div_unit (default build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        start;
    logic [2:0]  op;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          vectors;
    int          miscompares;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mul_div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .opA   (opA),
        .opB   (opB),
        .start (start),
        .op    (op),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Long operation: accept, count busy cycles, confirm hi/lo hold and done
    // stays low during RUN, then check result and the single done pulse.
    task automatic run_long(input string tag, input logic [2:0] code,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input bit inject);
        int nbusy;
        bit held;
        nbusy = 0;
        held  = 1'b1;
        @(negedge clk);
        start = 1'b1; op = code; opA = a; opB = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'b111; opA = $urandom; opB = $urandom;
        while (busy && nbusy < 40) begin
            nbusy++;
            if (hi !== m_hi || lo !== m_lo || done !== 1'b0) held = 1'b0;
            if (inject && nbusy == 10) begin
                start = 1'b1; op = 3'b101; opA = 32'd99;
            end else begin
                start = 1'b0; op = 3'b111;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, 32'(nbusy), 32'd32);
        check({tag, " hold_in_run"}, {31'd0, held}, 32'd1);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
        @(posedge clk); #1;
        check({tag, " done_clear"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run_move(input string tag, input logic [2:0] code, input logic [31:0] a,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input bit exp_done);
        @(negedge clk);
        start = 1'b1; op = code; opA = a; opB = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; op = 3'b111; opA = $urandom;
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, {31'd0, exp_done});
        m_hi = exp_hi;
        m_lo = exp_lo;
        @(posedge clk); #1;
        check({tag, " done_clear"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        int nbusy;
        vectors     = 0;
        miscompares = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        rst = 1'b1; start = 1'b0; op = 3'b111; opA = '0; opB = '0;

        // Reset state
        #2 rst = 1'b0;
        #1;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // Multiply
        run_long("mult_neg3x5", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_long("mult_neg3xneg5", 3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 32'd15, 1'b0);
        run_long("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_long("multu_2p32", 3'b001, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0);

        // Divide
        run_long("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_long("div_7_m2", 3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_long("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run_long("divu_by0", 3'b011, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0);
        run_long("div_neg_by0", 3'b010, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        run_long("divu_big", 3'b011, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);

        // Moves and no-ops
        run_move("mthi", 3'b100, 32'h1234, 32'h1234, 32'h0FFF_FFFF, 1'b1);
        run_move("mtlo", 3'b101, 32'h99, 32'h1234, 32'h99, 1'b1);
        run_move("nop110", 3'b110, 32'h5, 32'h1234, 32'h99, 1'b0);
        run_move("nop111", 3'b111, 32'h7, 32'h1234, 32'h99, 1'b0);

        // Start during busy is ignored
        run_long("divu_20_3_inj", 3'b011, 32'd20, 32'd3, 32'd2, 32'd6, 1'b1);

        // Reset aborts a running divide
        @(negedge clk);
        start = 1'b1; op = 3'b010; opA = 32'd100; opB = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; op = 3'b111;
        repeat (14) @(posedge clk);
        #1;
        check("abort running", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk) rst = 1'b1;
        ndone = 0;
        nbusy = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (busy) nbusy++;
        end
        check("abort no_done", 32'(ndone), 32'd0);
        check("abort no_busy", 32'(nbusy), 32'd0);
        check("abort hi_after", hi, 32'd0);
        check("abort lo_after", lo, 32'd0);

        // First accept after release behaves as from power-up
        run_long("divu_20_3_post", 3'b011, 32'd20, 32'd3, 32'd2, 32'd6, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
